// File: rtl/ddr_pkg.sv
// Shared DDR command encodings, mode-register words and init-sequencer state types.
package ddr_pkg;

  // {csN, rasN, casN, weN}
  localparam logic [3:0] CMD_DESEL = 4'b1111;
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_LMR   = 4'b0000;

  localparam logic [12:0] MR_DLL_RST   = 13'h121;
  localparam logic [12:0] MR_NORMAL    = 13'h021;
  localparam logic [12:0] EMR_DEFAULT  = 13'h000;
  localparam logic [12:0] ADDR_PRE_ALL = 13'h400;

  typedef enum logic [3:0] {
    StPwrWait,
    StCkeNop,
    StPre1,
    StEmrs,
    StMrsRst,
    StPre2,
    StAref1,
    StAref2,
    StMrs,
    StDllHold,
    StDone
  } init_state_e;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
  } ddr_cmd_t;

  // Command driven in the first cycle of a state; later cycles of the state are NOP/DESEL.
  function automatic ddr_cmd_t entry_cmd(input init_state_e st);
    ddr_cmd_t c;
    c = '{cmd: CMD_NOP, ba: 2'b00, addr: 13'h000};
    unique case (st)
      StPwrWait:      c.cmd = CMD_DESEL;
      StPre1, StPre2: begin c.cmd = CMD_PRE;  c.addr = ADDR_PRE_ALL; end
      StEmrs:         begin c.cmd = CMD_LMR;  c.ba = 2'b01; c.addr = EMR_DEFAULT; end
      StMrsRst:       begin c.cmd = CMD_LMR;  c.addr = MR_DLL_RST; end
      StAref1,
      StAref2:        c.cmd = CMD_AREF;
      StMrs:          begin c.cmd = CMD_LMR;  c.addr = MR_NORMAL; end
      default:        c.cmd = CMD_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ddr_init_seq_if.sv
// DDR command/address pins plus init-done flag; master drives, slave observes.
interface ddr_init_seq_if;
  logic        cke;
  logic        csN;
  logic        rasN;
  logic        casN;
  logic        weN;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        initDone;

  modport master (output cke, csN, rasN, casN, weN, ba, addr, initDone);
  modport slave  (input  cke, csN, rasN, casN, weN, ba, addr, initDone);
endinterface

// File: rtl/ddr_wait_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module ddr_wait_timer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= CNT_W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ddr_init_seq.sv
// DDR SDRAM power-up init sequencer: walks the JEDEC init commands, then holds NOP with initDone.
module ddr_init_seq
  import ddr_pkg::*;
#(
  parameter int unsigned WAIT_PWR = 26700,
  parameter int unsigned T_RP     = 3,
  parameter int unsigned T_MRD    = 2,
  parameter int unsigned T_RFC    = 10,
  parameter int unsigned DLL_WAIT = 200,
  parameter int unsigned CNT_W    = 16
) (
  input  logic           clk,
  input  logic           rst,
  ddr_init_seq_if.master ddr
);

  init_state_e      state_d, state_q, nxt_state;
  ddr_cmd_t         cmd_d, cmd_q;
  logic             cke_d, cke_q;
  logic             done_d, done_q;
  logic [CNT_W-1:0] dll_d, dll_q;
  logic [CNT_W-1:0] load_val;
  logic             timer_expired;
  logic             dll_ok;
  logic             advance;

  // Reset preloads WAIT_PWR so the reset interval itself stands in for the cycle before cycle 0.
  ddr_wait_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(WAIT_PWR)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (advance),
    .load_val_i(load_val),
    .expired_o (timer_expired)
  );

  assign dll_ok = (dll_q >= CNT_W'(DLL_WAIT));

  always_comb begin
    nxt_state = state_q;
    unique case (state_q)
      StPwrWait: nxt_state = StCkeNop;
      StCkeNop:  nxt_state = StPre1;
      StPre1:    nxt_state = StEmrs;
      StEmrs:    nxt_state = StMrsRst;
      StMrsRst:  nxt_state = StPre2;
      StPre2:    nxt_state = StAref1;
      StAref1:   nxt_state = StAref2;
      StAref2:   nxt_state = StMrs;
      StMrs:     nxt_state = dll_ok ? StDone : StDllHold;
      StDllHold: nxt_state = StDone;
      default:   nxt_state = StDone;
    endcase
  end

  always_comb begin
    advance = timer_expired && (state_q != StDone) && ((state_q != StDllHold) || dll_ok);
    state_d = advance ? nxt_state : state_q;

    load_val = '0;
    unique case (nxt_state)
      StCkeNop, StPre1, StPre2: load_val = CNT_W'(T_RP - 1);
      StEmrs, StMrsRst, StMrs:  load_val = CNT_W'(T_MRD - 1);
      StAref1, StAref2:         load_val = CNT_W'(T_RFC - 1);
      default:                  load_val = '0;
    endcase

    if (advance) begin
      cmd_d = entry_cmd(nxt_state);
    end else begin
      cmd_d = '{cmd: (state_q == StPwrWait) ? CMD_DESEL : CMD_NOP, ba: 2'b00, addr: 13'h000};
    end
    cke_d  = (state_d != StPwrWait);
    done_d = (state_d == StDone);

    // DLL counter starts with the DLL-reset MRS and saturates at DLL_WAIT.
    dll_d = dll_q;
    if (advance && (nxt_state == StMrsRst)) begin
      dll_d = CNT_W'(1);
    end else if ((dll_q != '0) && !dll_ok) begin
      dll_d = dll_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StPwrWait;
      cmd_q   <= '{cmd: CMD_DESEL, ba: 2'b00, addr: 13'h000};
      cke_q   <= 1'b0;
      done_q  <= 1'b0;
      dll_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cke_q   <= cke_d;
      done_q  <= done_d;
      dll_q   <= dll_d;
    end
  end

  assign ddr.cke      = cke_q;
  assign ddr.csN      = cmd_q.cmd[3];
  assign ddr.rasN     = cmd_q.cmd[2];
  assign ddr.casN     = cmd_q.cmd[1];
  assign ddr.weN      = cmd_q.cmd[0];
  assign ddr.ba       = cmd_q.ba;
  assign ddr.addr     = cmd_q.addr;
  assign ddr.initDone = done_q;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Directed bench for ddr_init_seq: nominal, DLL-dominated and back-to-back timelines plus resets.
module tb_ddr_init_seq;

  typedef struct {
    int cke_at;
    int pre1;
    int emrs;
    int mrsr;
    int pre2;
    int aref1;
    int aref2;
    int mrs;
    int done_at;
  } sched_t;

  // Hand-derived command timelines (cycle numbers after rst release).
  localparam sched_t SchedNom = '{10, 12, 14, 16, 18, 20, 24, 28, 30};
  localparam sched_t SchedDll = '{10, 12, 14, 16, 18, 20, 24, 28, 36};
  localparam sched_t SchedB2b = '{1, 2, 3, 4, 5, 6, 7, 8, 9};

  // {cke, csN, rasN, casN, weN, ba, addr, initDone}
  localparam logic [20:0] RstVec  = {1'b0, 4'b1111, 2'b00, 13'h000, 1'b0};
  localparam logic [20:0] DoneVec = {1'b1, 4'b0111, 2'b00, 13'h000, 1'b1};

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  ddr_init_seq_if if_a ();
  ddr_init_seq_if if_b ();
  ddr_init_seq_if if_c ();

  ddr_init_seq #(
    .WAIT_PWR(10), .T_RP(2), .T_MRD(2), .T_RFC(4), .DLL_WAIT(8), .CNT_W(16)
  ) u_dut_a (
    .clk(clk), .rst(rst_a), .ddr(if_a)
  );

  ddr_init_seq #(
    .WAIT_PWR(10), .T_RP(2), .T_MRD(2), .T_RFC(4), .DLL_WAIT(20), .CNT_W(16)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .ddr(if_b)
  );

  ddr_init_seq #(
    .WAIT_PWR(1), .T_RP(1), .T_MRD(1), .T_RFC(1), .DLL_WAIT(1), .CNT_W(16)
  ) u_dut_c (
    .clk(clk), .rst(rst_c), .ddr(if_c)
  );

  logic [20:0] obs_a, obs_b, obs_c;
  assign obs_a = {if_a.cke, if_a.csN, if_a.rasN, if_a.casN, if_a.weN, if_a.ba, if_a.addr,
                  if_a.initDone};
  assign obs_b = {if_b.cke, if_b.csN, if_b.rasN, if_b.casN, if_b.weN, if_b.ba, if_b.addr,
                  if_b.initDone};
  assign obs_c = {if_c.cke, if_c.csN, if_c.rasN, if_c.casN, if_c.weN, if_c.ba, if_c.addr,
                  if_c.initDone};

  function automatic logic [20:0] exp_vec(input sched_t s, input int k);
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] addr;
    cmd  = (k < s.cke_at) ? 4'b1111 : 4'b0111;
    ba   = 2'b00;
    addr = 13'h000;
    if (k == s.pre1 || k == s.pre2) begin cmd = 4'b0010; addr = 13'h400; end
    if (k == s.emrs)                begin cmd = 4'b0000; ba = 2'b01; end
    if (k == s.mrsr)                begin cmd = 4'b0000; addr = 13'h121; end
    if (k == s.aref1 || k == s.aref2) cmd = 4'b0001;
    if (k == s.mrs)                 begin cmd = 4'b0000; addr = 13'h021; end
    return {(k >= s.cke_at), cmd, ba, addr, (k >= s.done_at)};
  endfunction

  task automatic test_reset();
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (3) @(negedge clk);
    n_total++;
    if (obs_a !== RstVec) $display("FAIL reset_a: got %h want %h", obs_a, RstVec);
    else n_pass++;
    n_total++;
    if (obs_b !== RstVec) $display("FAIL reset_b: got %h want %h", obs_b, RstVec);
    else n_pass++;
    n_total++;
    if (obs_c !== RstVec) $display("FAIL reset_c: got %h want %h", obs_c, RstVec);
    else n_pass++;
  endtask

  task automatic test_nominal();
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      n_total++;
      if (obs_a !== exp_vec(SchedNom, k))
        $display("FAIL nominal cycle %0d: got %h want %h", k, obs_a, exp_vec(SchedNom, k));
      else n_pass++;
    end
  endtask

  task automatic test_hold();
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      n_total++;
      if (obs_a !== DoneVec) $display("FAIL hold cycle %0d: got %h want %h", k, obs_a, DoneVec);
      else n_pass++;
    end
  endtask

  task automatic test_reset_in_done();
    @(negedge clk);
    #2 rst_a = 1'b1;
    #1;
    n_total++;
    if (if_a.initDone !== 1'b0) $display("FAIL done_rst_initdone: got %b want 0", if_a.initDone);
    else n_pass++;
    n_total++;
    if (obs_a !== RstVec) $display("FAIL done_rst_outputs: got %h want %h", obs_a, RstVec);
    else n_pass++;
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k <= 35; k++) begin
      @(negedge clk);
      n_total++;
      if (obs_a !== exp_vec(SchedNom, k))
        $display("FAIL rerun cycle %0d: got %h want %h", k, obs_a, exp_vec(SchedNom, k));
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k <= 19; k++) begin
      @(negedge clk);
      n_total++;
      if (obs_a !== exp_vec(SchedNom, k))
        $display("FAIL midop_pre cycle %0d: got %h want %h", k, obs_a, exp_vec(SchedNom, k));
      else n_pass++;
    end
    // Assert between edges; outputs must clear before the next posedge.
    #2 rst_a = 1'b1;
    #1;
    n_total++;
    if (obs_a !== RstVec) $display("FAIL midop_async_rst: got %h want %h", obs_a, RstVec);
    else n_pass++;
    @(negedge clk);
    rst_a = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      @(negedge clk);
      n_total++;
      if (obs_a !== exp_vec(SchedNom, k))
        $display("FAIL midop_rerun cycle %0d: got %h want %h", k, obs_a, exp_vec(SchedNom, k));
      else n_pass++;
    end
  endtask

  task automatic test_dll_dominated();
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 0; k <= 45; k++) begin
      @(negedge clk);
      n_total++;
      if (obs_b !== exp_vec(SchedDll, k))
        $display("FAIL dll cycle %0d: got %h want %h", k, obs_b, exp_vec(SchedDll, k));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    rst_c = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      n_total++;
      if (obs_c !== exp_vec(SchedB2b, k))
        $display("FAIL b2b cycle %0d: got %h want %h", k, obs_c, exp_vec(SchedB2b, k));
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_hold();
    test_reset_in_done();
    test_reset_mid_op();
    test_dll_dominated();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
